program_loader: RTL and testbench

Loads a program image into the processor's instruction store before execution. Bytes arrive over an 8-bit valid/ready stream and are packed MSB-first into I_SIZE-bit instructions. Each packed instruction goes out on a synchronous write port at consecutive addresses from 0. The CPU is held off while loading; this block is the write-side counterpart of the combinational program-memory read port.

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/instr_assembler.sv | 38 +++
 rtl/program_loader.sv | 137 +++++++++++++
 tb/tb_program_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and helpers for the program loader: FSM state encoding and
// instruction-width arithmetic.
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  function automatic int bytes_per_word(input int i_size);
    return i_size / 8;
  endfunction

  // Instructions must be a whole, non-zero number of bytes.
  function automatic bit width_ok(input int i_size);
    return (i_size % 8 == 0) && (i_size >= 8);
  endfunction

endpackage

// File: rtl/instr_assembler.sv
// Packs a stream of accepted bytes MSB-first into I_SIZE-bit words and flags
// the byte that completes each word.
module instr_assembler
  import program_loader_pkg::*;
#(
  parameter int I_SIZE = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [I_SIZE-1:0] word,
  output logic              word_done
);

  localparam int BYTES = bytes_per_word(I_SIZE);
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CW-1:0]     cnt;
  logic [I_SIZE-1:0] shreg;

  // The completed word includes the byte arriving this cycle, so it can be
  // registered downstream without waiting for the shift to land.
  assign word      = (shreg << 8) | I_SIZE'(byte_in);
  assign word_done = accept && (cnt == CW'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (accept) begin
      shreg <= word;
      cnt   <= word_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a program image into instruction memory while holding the CPU off.
// Optional trailing XOR checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int P_SIZE = 6,
  parameter int I_SIZE = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [P_SIZE:0]   word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [P_SIZE-1:0] mem_addr,
  output logic [I_SIZE-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  if (!width_ok(I_SIZE)) begin : g_bad_width
    $error("program_loader: I_SIZE must be a non-zero multiple of 8");
  end

  localparam logic [P_SIZE:0] DEPTH = (P_SIZE + 1)'(2 ** P_SIZE);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit            CSUM_EN    = 1'b1;
  localparam loader_state_t AFTER_LOAD = CHECK;
`else
  localparam bit            CSUM_EN    = 1'b0;
  localparam loader_state_t AFTER_LOAD = DONE;
`endif

  loader_state_t     state, state_next;
  logic [P_SIZE:0]   total, word_idx, wc_sat;
  logic [P_SIZE-1:0] addr_cnt;
  logic [I_SIZE-1:0] word;
  logic              launch, accept, asm_accept, word_done, last_word;

  assign wc_sat     = (word_count > DEPTH) ? DEPTH : word_count;
  assign launch     = start && (state == IDLE || state == DONE);
  assign accept     = rx_valid && rx_ready;
  assign asm_accept = accept && (state == LOAD);
  assign last_word  = word_done && (word_idx == total - 1'b1);

  instr_assembler #(.I_SIZE(I_SIZE)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (launch),
    .accept    (asm_accept),
    .byte_in   (rx_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_next = (wc_sat == '0) ? AFTER_LOAD : LOAD;
      end
      LOAD: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (last_word) state_next = AFTER_LOAD;
      end
      CHECK: begin
        rx_ready = CSUM_EN;
        busy     = 1'b1;
        if (accept) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpu_hold = busy;

  // mem_addr captures the address of the word being written; addr_cnt has
  // already moved on so the next word can complete back-to-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      total     <= '0;
      word_idx  <= '0;
      addr_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= word_done;
      if (launch) begin
        total    <= wc_sat;
        word_idx <= '0;
        addr_cnt <= '0;
      end else if (word_done) begin
        mem_wdata <= word;
        mem_addr  <= addr_cnt;
        addr_cnt  <= addr_cnt + 1'b1;
        word_idx  <= word_idx + 1'b1;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (reset || launch) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (asm_accept) begin
      csum <= csum ^ rx_data;
    end else if (state == CHECK && accept) begin
      err_q <= (rx_data != csum);
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: random byte images, expected writes
// computed from MSB-first packing and checked by an independent monitor.
module tb_program_loader;

  localparam int P = 6;
  localparam int I = 24;
  localparam int B = I / 8;

  logic         clk = 1'b0;
  logic         reset, start, rx_valid;
  logic [P:0]   word_count;
  logic [7:0]   rx_data;
  logic         rx_ready, mem_we, cpu_hold, busy, done, error;
  logic [P-1:0] mem_addr;
  logic [I-1:0] mem_wdata;

  int vectors = 0;
  int misc    = 0;

  logic [P+I-1:0] exp_q[$];
  logic [P+I-1:0] mon_e;
  logic [7:0]     img[$];

  program_loader #(.P_SIZE(P), .I_SIZE(I)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        misc++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(mon_e[P+I-1:I]));
        check("write_data", 32'(mem_wdata), 32'(mon_e[I-1:0]));
      end
    end
  end

  task automatic fill_random(input int n_words);
    img.delete();
    for (int k = 0; k < n_words * B; k++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  // Called and returns at a negedge; a byte presented while rx_ready is high
  // is taken at the following posedge.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int waited;
    if (stall) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (rx_ready !== 1'b1) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic run_load(input int wc, input bit stall, input bit use_csum, input logic [7:0] csum_in);
    int         n;
    logic [I-1:0] w;
    logic [7:0] x;
    n = (wc > 2 ** P) ? 2 ** P : wc;
    start      = 1'b1;
    word_count = (P + 1)'(wc);
    @(negedge clk);
    start = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("busy_after_start", 32'(busy), 32'd1);
    check("rx_ready_after_start", 32'(rx_ready), 32'd1);
`else
    check("busy_after_start", 32'(busy), 32'(n > 0));
    check("rx_ready_after_start", 32'(rx_ready), 32'(n > 0));
`endif
    x = 8'h00;
    for (int wi = 0; wi < n; wi++) begin
      w = '0;
      for (int bi = 0; bi < B; bi++) begin
        w = w * 256 + I'(img[wi * B + bi]);
        x = x ^ img[wi * B + bi];
      end
      exp_q.push_back({P'(wi), w});
      for (int bi = 0; bi < B; bi++) begin
        check("cpu_hold_load", 32'(cpu_hold), 32'd1);
        send_byte(img[wi * B + bi], stall);
      end
    end
    if (n > 0) check("mem_we_with_last", 32'(mem_we), 32'd1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("done_before_csum", 32'(done), 32'd0);
    send_byte(use_csum ? csum_in : x, stall);
    check("done_after_csum", 32'(done), 32'd1);
    check("error", 32'(error), use_csum ? 32'(csum_in != x) : 32'd0);
`else
    check("done_after_last", 32'(done), 32'd1);
    check("error", 32'(error), 32'd0);
`endif
    rx_valid = 1'b0;
    check("busy_done", 32'(busy), 32'd0);
    check("cpu_hold_done", 32'(cpu_hold), 32'd0);
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("rx_ready_done", 32'(rx_ready), 32'd0);
    check("done_held", 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    word_count = '0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed image from the plan, back-to-back bytes.
    img.delete();
    img.push_back(8'h12); img.push_back(8'h34); img.push_back(8'h56);
    img.push_back(8'hAB); img.push_back(8'hCD); img.push_back(8'hEF);
    run_load(2, 1'b0, 1'b0, 8'h00);

    // Single word with random valid gaps.
    for (int r = 0; r < 3; r++) begin
      fill_random(1);
      run_load(1, 1'b1, 1'b0, 8'h00);
    end

    // Empty load.
    run_load(0, 1'b0, 1'b0, 8'h00);

    // Full depth, then an oversize request that must saturate.
    fill_random(64);
    run_load(64, 1'b0, 1'b0, 8'h00);
    fill_random(64);
    run_load(100, 1'b1, 1'b0, 8'h00);

    // Random sizes and pacing.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 8);
      fill_random(n);
      run_load(n, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
    end

    // Reset part-way through word 0, then a fresh load.
    fill_random(2);
    start      = 1'b1;
    word_count = 7'd2;
    @(negedge clk);
    start = 1'b0;
    send_byte(img[0], 1'b0);
    send_byte(img[1], 1'b0);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check_reset_outputs("midload");
    reset = 1'b0;
    @(negedge clk);
    fill_random(1);
    run_load(1, 1'b0, 1'b0, 8'h00);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    img.delete();
    img.push_back(8'h01); img.push_back(8'h02); img.push_back(8'h03);
    run_load(1, 1'b0, 1'b1, 8'h00);
    img.delete();
    img.push_back(8'h01); img.push_back(8'h01); img.push_back(8'h00);
    run_load(1, 1'b0, 1'b1, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
